// File: rtl/imem_fetch_responder_pkg.sv
// Shared types and constants for the instruction-memory fetch responder.
// The FSM state encoding, the reset fetch value and the default memory depth live here.
package imem_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } imem_state_e;

    // NOP (0x00000013) laid out in fetch halfword order: first halfword in [31:16]
    localparam logic [31:0] IMEM_NOP_PAIR = 32'h0013_0000;
    localparam int          IMEM_DEPTH    = 512;

    function automatic logic hw_par(input logic [15:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/imem_fetch_responder_if.sv
// Fetch and loader signal bundle between the loader/fetch FIFO (master) and the responder (slave).
// par_err is present only when IMEM_PARITY_EN is defined.
interface imem_fetch_responder_if;
    logic        mem_rq;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_valid;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        ld_restart;
    logic        run;
`ifdef IMEM_PARITY_EN
    logic        par_err;
`endif

    modport master (
`ifdef IMEM_PARITY_EN
        input  par_err,
`endif
        output mem_rq, mem_addr, ld_valid, ld_data, ld_last, ld_restart,
        input  mem_data, mem_valid, ld_ready, run
    );

    modport slave (
`ifdef IMEM_PARITY_EN
        output par_err,
`endif
        input  mem_rq, mem_addr, ld_valid, ld_data, ld_last, ld_restart,
        output mem_data, mem_valid, ld_ready, run
    );
endinterface

// File: rtl/imem_fetch_responder_bank.sv
// DEPTH x W single-port RAM with a registered read port that holds between reads.
// Latency: 1 cycle read. No backpressure; the read register resets to RST_VAL.
module imem_bank #(
    parameter int             DEPTH   = 512,
    parameter int             W       = 16,
    parameter logic [W-1:0]   RST_VAL = '0,
    localparam int            AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [W-1:0]  wdat_i,
    output logic [W-1:0]  rdat_o
);
    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdat_q;

    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            mem[addr_i] <= wdat_i;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdat_q <= RST_VAL;
        end else if (en_i && !we_i) begin
            rdat_q <= mem[addr_i];
        end
    end

    assign rdat_o = rdat_q;
endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction memory: sequential loader fills even/odd halfword banks, then serves any halfword-aligned 32-bit fetch window.
// Latency: fetch sampled at edge N, data/mem_valid at N+1. No fetch backpressure; loader never stalls in LOAD. Optional IMEM_PARITY_EN.
module imem_fetch_responder
    import imem_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH
) (
    input  logic                    clk,
    input  logic                    resetn,
    imem_fetch_responder_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
    localparam int BW = 17;
    localparam logic [BW-1:0] EVEN_RST = {hw_par(IMEM_NOP_PAIR[31:16]), IMEM_NOP_PAIR[31:16]};
    localparam logic [BW-1:0] ODD_RST  = {hw_par(IMEM_NOP_PAIR[15:0]),  IMEM_NOP_PAIR[15:0]};
`else
    localparam int BW = 16;
    localparam logic [BW-1:0] EVEN_RST = IMEM_NOP_PAIR[31:16];
    localparam logic [BW-1:0] ODD_RST  = IMEM_NOP_PAIR[15:0];
`endif

    imem_state_e   state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic          sel_q, sel_d;
    logic          mem_valid_q;
    logic          wr_en, fetch_acc;

    logic [AW:0]   hidx;
    logic [AW-1:0] widx, widx_nxt, even_addr, odd_addr;
    logic [BW-1:0] even_wdat, odd_wdat, even_rd, odd_rd;
    logic          unused_addr;

    assign hidx        = bus.mem_addr[AW+1:1];
    assign widx        = hidx[AW:1];
    assign widx_nxt    = widx + AW'(1);
    assign unused_addr = ^{bus.mem_addr[31:AW+2], bus.mem_addr[0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= LOAD;
            wptr_q      <= '0;
            sel_q       <= 1'b0;
            mem_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            sel_q       <= sel_d;
            mem_valid_q <= fetch_acc;
        end
    end

    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        sel_d     = sel_q;
        wr_en     = 1'b0;
        fetch_acc = 1'b0;
        case (state_q)
            LOAD: begin
                if (bus.ld_valid) begin
                    wr_en  = 1'b1;
                    wptr_d = wptr_q + AW'(1);
                    if (bus.ld_last) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                fetch_acc = bus.mem_rq;
                if (bus.mem_rq) begin
                    sel_d = hidx[0];
                end
                if (bus.ld_restart) begin
                    state_d = LOAD;
                    wptr_d  = '0;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Odd halfword index needs the next word from the even bank, wrapping at the top.
    assign even_addr = (state_q == LOAD) ? wptr_q : (hidx[0] ? widx_nxt : widx);
    assign odd_addr  = (state_q == LOAD) ? wptr_q : widx;

`ifdef IMEM_PARITY_EN
    assign even_wdat = {hw_par(bus.ld_data[15:0]),  bus.ld_data[15:0]};
    assign odd_wdat  = {hw_par(bus.ld_data[31:16]), bus.ld_data[31:16]};
`else
    assign even_wdat = bus.ld_data[15:0];
    assign odd_wdat  = bus.ld_data[31:16];
`endif

    imem_bank #(.DEPTH(DEPTH), .W(BW), .RST_VAL(EVEN_RST)) even (
        .clk    (clk),
        .resetn (resetn),
        .en_i   (wr_en | fetch_acc),
        .we_i   (wr_en),
        .addr_i (even_addr),
        .wdat_i (even_wdat),
        .rdat_o (even_rd)
    );

    imem_bank #(.DEPTH(DEPTH), .W(BW), .RST_VAL(ODD_RST)) odd (
        .clk    (clk),
        .resetn (resetn),
        .en_i   (wr_en | fetch_acc),
        .we_i   (wr_en),
        .addr_i (odd_addr),
        .wdat_i (odd_wdat),
        .rdat_o (odd_rd)
    );

    assign bus.mem_data  = sel_q ? {odd_rd[15:0], even_rd[15:0]} : {even_rd[15:0], odd_rd[15:0]};
    assign bus.mem_valid = mem_valid_q;
    assign bus.ld_ready  = (state_q == LOAD);
    assign bus.run       = (state_q == RUN);

`ifdef IMEM_PARITY_EN
    logic par_err_q, par_err_d, par_hit;

    // Bank outputs are registered, so the check is combinational on them to flag on the data cycle.
    assign par_hit   = mem_valid_q & ((^even_rd) | (^odd_rd));
    assign par_err_d = (state_q == RUN && bus.ld_restart) ? 1'b0 : (par_err_q | par_hit);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign bus.par_err = par_err_q | par_hit;
`endif
endmodule

// File: tb/tb_imem_fetch_responder.sv
// Self-checking bench: directed table, multi-cycle corner sequences, and random fetches vs a halfword-array model.
module tb_imem_fetch_responder;
    import imem_pkg::*;

    localparam int DEPTH = 512;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    imem_fetch_responder_if bus();

    imem_fetch_responder #(.DEPTH(DEPTH)) u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference: flat halfword array, halfword k at byte address 2k
    logic [15:0] mhw [2*DEPTH];
    int          mwp;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vt[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_fetch(input logic [31:0] a);
        int h;
        h = int'((a >> 1) & (2*DEPTH-1));
        return {mhw[h], mhw[(h+1) % (2*DEPTH)]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] d, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_data  = d;
        bus.ld_last  = last;
        step();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        mhw[2*mwp]   = d[15:0];
        mhw[2*mwp+1] = d[31:16];
        mwp = (mwp + 1) % DEPTH;
    endtask

    task automatic fetch(input logic [31:0] a, input string name);
        bus.mem_rq   = 1'b1;
        bus.mem_addr = a;
        step();
        bus.mem_rq   = 1'b0;
        chk({name, " valid"}, 32'(bus.mem_valid), 32'd1);
        chk(name, bus.mem_data, model_fetch(a));
    endtask

    task automatic restart();
        bus.ld_restart = 1'b1;
        step();
        bus.ld_restart = 1'b0;
        mwp = 0;
    endtask

    logic [31:0] exp_d;
    logic        rq;
    logic [31:0] ra;

    initial begin
        resetn         = 1'b0;
        bus.mem_rq     = 1'b0;
        bus.mem_addr   = '0;
        bus.ld_valid   = 1'b0;
        bus.ld_data    = '0;
        bus.ld_last    = 1'b0;
        bus.ld_restart = 1'b0;
        mwp            = 0;
        repeat (2) step();
        resetn = 1'b1;
        step();

        chk("reset mem_data", bus.mem_data, 32'h0013_0000);
        chk("reset mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("reset ld_ready", 32'(bus.ld_ready), 32'd1);
        chk("reset run", 32'(bus.run), 32'd0);
`ifdef IMEM_PARITY_EN
        chk("reset par_err", 32'(bus.par_err), 32'd0);
`endif

        // Fetch in LOAD is dropped
        bus.mem_rq = 1'b1;
        bus.mem_addr = 32'h0;
        step();
        bus.mem_rq = 1'b0;
        chk("load rq valid", 32'(bus.mem_valid), 32'd0);
        chk("load rq data held", bus.mem_data, 32'h0013_0000);

        load_word(32'h2222_1111, 1'b0);
        load_word(32'h4444_3333, 1'b0);
        chk("run before last", 32'(bus.run), 32'd0);
        // Fetch presented alongside the last loader word is dropped
        bus.mem_rq = 1'b1;
        bus.mem_addr = 32'h0;
        load_word(32'h6666_5555, 1'b1);
        bus.mem_rq = 1'b0;
        chk("rq with last dropped", 32'(bus.mem_valid), 32'd0);
        chk("run after last", 32'(bus.run), 32'd1);
        chk("ld_ready in run", 32'(bus.ld_ready), 32'd0);

        vt[0] = '{32'h0, 32'h1111_2222, "tbl 0x0"};
        vt[1] = '{32'h2, 32'h2222_3333, "tbl 0x2"};
        vt[2] = '{32'h6, 32'h4444_5555, "tbl 0x6"};
        vt[3] = '{32'h4, 32'h3333_4444, "tbl 0x4"};
        vt[4] = '{32'h9, 32'h5555_6666, "tbl 0x9 bit0"};
        for (int i = 0; i < 5; i++) begin
            bus.mem_rq   = 1'b1;
            bus.mem_addr = vt[i].addr;
            step();
            bus.mem_rq   = 1'b0;
            chk({vt[i].name, " valid"}, 32'(bus.mem_valid), 32'd1);
            chk(vt[i].name, bus.mem_data, vt[i].exp);
        end

        // Back-to-back then an idle cycle
        fetch(32'h0, "b2b 0x0");
        fetch(32'h2, "b2b 0x2");
        fetch(32'h4, "b2b 0x4");
        step();
        chk("idle valid", 32'(bus.mem_valid), 32'd0);
        chk("idle data held", bus.mem_data, 32'h3333_4444);

        // Loader ignored in RUN
        bus.ld_valid = 1'b1;
        bus.ld_data  = 32'hDEAD_BEEF;
        bus.ld_last  = 1'b1;
        step();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        chk("run kept", 32'(bus.run), 32'd1);
        fetch(32'h0, "ignored loader 0x0");

        // Restart with a fetch in the same cycle
        bus.mem_rq = 1'b1;
        bus.mem_addr = 32'h2;
        restart();
        bus.mem_rq = 1'b0;
        chk("restart fetch valid", 32'(bus.mem_valid), 32'd1);
        chk("restart fetch data", bus.mem_data, 32'h2222_3333);
        chk("restart run", 32'(bus.run), 32'd0);
        chk("restart ld_ready", 32'(bus.ld_ready), 32'd1);
        load_word(32'hAAAA_BBBB, 1'b1);
        fetch(32'h0, "reload 0x0");
        chk("reload 0x0 const", bus.mem_data, 32'hBBBB_AAAA);
        fetch(32'h2, "reload 0x2");
        fetch(32'h4, "retained word1");
        chk("retained word1 const", bus.mem_data, 32'h3333_4444);

        // Reset in the middle of a load
        restart();
        load_word(32'h1234_5678, 1'b0);
        load_word(32'h9ABC_DEF0, 1'b0);
        #2 resetn = 1'b0;
        #1;
        chk("midreset run", 32'(bus.run), 32'd0);
        chk("midreset ld_ready", 32'(bus.ld_ready), 32'd1);
        chk("midreset mem_data", bus.mem_data, 32'h0013_0000);
        step();
        resetn = 1'b1;
        mwp = 0;
        load_word(32'hCAFE_F00D, 1'b1);
        fetch(32'h0, "after midreset 0x0");
        chk("after midreset const", bus.mem_data, 32'hF00D_CAFE);
        fetch(32'h4, "after midreset 0x4");

        // Full image for wrap-around
        restart();
        for (int i = 0; i < DEPTH; i++) begin
            load_word({16'(2*i+1), 16'(2*i)}, i == DEPTH-1);
        end
        fetch(32'(4*DEPTH-2), "wrap top");
        chk("wrap top const", bus.mem_data, {16'(2*DEPTH-1), 16'h0000});
        fetch(32'(4*DEPTH), "alias 0");
        chk("alias 0 const", bus.mem_data, 32'h0000_0001);

        // Random image and random fetch traffic
        restart();
        for (int i = 0; i < DEPTH; i++) begin
            load_word($urandom, i == DEPTH-1);
        end
        exp_d = bus.mem_data;
        for (int i = 0; i < 300; i++) begin
            rq = 1'($urandom_range(0, 1));
            ra = $urandom;
            bus.mem_rq   = rq;
            bus.mem_addr = ra;
            step();
            if (rq) exp_d = model_fetch(ra);
            chk("rand valid", 32'(bus.mem_valid), 32'(rq));
            chk("rand data", bus.mem_data, exp_d);
        end
        bus.mem_rq = 1'b0;
        step();

`ifdef IMEM_PARITY_EN
        fetch(32'h4, "par clean 0x4");
        chk("par clean", 32'(bus.par_err), 32'd0);
        u_dut.odd.mem[1][0] = ~u_dut.odd.mem[1][0];
        bus.mem_rq = 1'b1;
        bus.mem_addr = 32'h4;
        step();
        bus.mem_rq = 1'b0;
        chk("par flip detect", 32'(bus.par_err), 32'd1);
        fetch(32'h0, "par later clean");
        chk("par sticky", 32'(bus.par_err), 32'd1);
        step();
        chk("par sticky idle", 32'(bus.par_err), 32'd1);
        restart();
        chk("par cleared", 32'(bus.par_err), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
